// File: rtl/nfu3_pkg.sv
// Shared definitions for the NFU-3 sigmoid stage.
// Holds the controller state encoding and the segment count and pipeline
// latency, so that the nfu_3 datapath and its sequencer agree on both.
package nfu3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } nfu3_state_t;

  // Segments (and coefficient words) per piecewise-linear table load.
  localparam int NFU3_NSEG = 16;

  // Cycles from an input being sampled to its sigmoid result being valid.
  localparam int NFU3_LAT = 2;

endpackage

// File: rtl/nfu3_valid_pipe.sv
// LAT-deep valid shift register that tracks occupancy of a fixed-latency,
// non-stalling datapath stage.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset, clears every stage
//   vld_head valid entering the pipeline this cycle
//   vld_tail valid leaving the pipeline, LAT cycles after vld_head
module nfu3_valid_pipe #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vld_head,
  output logic vld_tail
);

  logic [LAT-1:0] vld_p;

  generate
    if (LAT == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p <= '0;
        else        vld_p <= vld_head;
      end
    end else begin : g_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p <= '0;
        else        vld_p <= {vld_p[LAT-2:0], vld_head};
      end
    end
  endgenerate

  assign vld_tail = vld_p[LAT-1];

endmodule

// File: rtl/nfu3_ctrl.sv
// Sequencer for the NFU-3 sigmoid stage.
// Streams NSEG {Ai, Bi} coefficient words into the lane coefficient RAMs,
// then admits i_num_vec NFU-2 vectors and tracks them through the
// fixed-latency NFU-3 pipeline, flagging each result and the last one.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_cfg_start       begin a coefficient load (IDLE only)
//   i_coef_valid/data coefficient word stream, o_coef_ready handshake
//   o_load_coef       coefficient RAM write enable, with o_coef_addr/o_coef
//   o_cfg_done        pulse with the final coefficient write
//   i_run_start       begin a run of i_num_vec vectors (IDLE, loaded only)
//   i_in_valid        NFU-2 vector valid, o_in_ready handshake
//   o_out_valid       NFU-3 result valid
//   o_busy            controller is not IDLE
//   o_run_done        pulse with the last result of a run
module nfu3_ctrl
  import nfu3_pkg::*;
#(
  parameter int  N    = 16,
  parameter int  NSEG = NFU3_NSEG,
  parameter int  LAT  = NFU3_LAT,
  parameter int  CNTW = 16,
  localparam int AW   = $clog2(NSEG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_cfg_start,
  input  logic            i_coef_valid,
  input  logic [2*N-1:0]  i_coef_data,
  output logic            o_coef_ready,
  output logic            o_load_coef,
  output logic [AW-1:0]   o_coef_addr,
  output logic [2*N-1:0]  o_coef,
  output logic            o_cfg_done,
  input  logic            i_run_start,
  input  logic [CNTW-1:0] i_num_vec,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  output logic            o_out_valid,
  output logic            o_busy,
  output logic            o_run_done
);

  nfu3_state_t     state_q, state_d;
  logic [AW-1:0]   wr_idx_q;
  logic            coef_loaded_q;
  logic [CNTW-1:0] in_left_q;
  logic [CNTW-1:0] out_left_q;

  logic coef_hs, coef_last, in_hs, cfg_accept, run_accept;

  assign coef_hs    = i_coef_valid && o_coef_ready;
  assign coef_last  = coef_hs && (wr_idx_q == AW'(NSEG - 1));
  assign in_hs      = i_in_valid && o_in_ready;
  assign cfg_accept = (state_q == IDLE) && i_cfg_start;
  // cfg start takes priority over a simultaneous run start.
  assign run_accept = (state_q == IDLE) && !i_cfg_start && i_run_start &&
                      coef_loaded_q && (i_num_vec != '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_accept)      state_d = LOAD;
        else if (run_accept) state_d = RUN;
      end
      LOAD:  if (coef_last) state_d = IDLE;
      RUN:   if (in_hs && (in_left_q == CNTW'(1))) state_d = DRAIN;
      DRAIN: if (o_run_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_coef_ready = (state_q == LOAD);
    o_in_ready   = (state_q == RUN) && (in_left_q != '0);
    o_busy       = (state_q != IDLE);
    o_run_done   = (state_q == DRAIN) && o_out_valid && (out_left_q == CNTW'(1));
  end

  // Coefficient write stage: one cycle after each accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_load_coef <= 1'b0;
      o_cfg_done  <= 1'b0;
      o_coef_addr <= '0;
      o_coef      <= '0;
    end else begin
      o_load_coef <= coef_hs;
      o_cfg_done  <= coef_last;
      if (coef_hs) begin
        o_coef_addr <= wr_idx_q;
        o_coef      <= i_coef_data;
      end
    end
  end

  // The write index only moves on a handshake, so valid gaps never skip
  // an address. A new load invalidates the table until it completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q      <= '0;
      coef_loaded_q <= 1'b0;
    end else begin
      if (cfg_accept) begin
        wr_idx_q      <= '0;
        coef_loaded_q <= 1'b0;
      end else if (coef_hs) begin
        wr_idx_q <= wr_idx_q + 1'b1;
        if (coef_last) coef_loaded_q <= 1'b1;
      end
    end
  end

  // Vector counters: inputs still to admit, results still to emerge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_left_q  <= '0;
      out_left_q <= '0;
    end else if (run_accept) begin
      in_left_q  <= i_num_vec;
      out_left_q <= i_num_vec;
    end else begin
      if (in_hs) in_left_q <= in_left_q - 1'b1;
      if (o_out_valid && (out_left_q != '0)) out_left_q <= out_left_q - 1'b1;
    end
  end

  // Occupancy of the NFU-3 datapath; results leave LAT cycles after entry.
  nfu3_valid_pipe #(
    .LAT (LAT)
  ) u_valid_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .vld_head (in_hs),
    .vld_tail (o_out_valid)
  );

endmodule

// File: tb/tb_nfu3_ctrl.sv
module tb_nfu3_ctrl;

  localparam int N    = 16;
  localparam int NSEG = 16;
  localparam int LAT  = 2;
  localparam int CNTW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_cfg_start = 1'b0;
  logic            i_coef_valid = 1'b0;
  logic [2*N-1:0]  i_coef_data = '0;
  logic            o_coef_ready;
  logic            o_load_coef;
  logic [3:0]      o_coef_addr;
  logic [2*N-1:0]  o_coef;
  logic            o_cfg_done;
  logic            i_run_start = 1'b0;
  logic [CNTW-1:0] i_num_vec = '0;
  logic            i_in_valid = 1'b0;
  logic            o_in_ready;
  logic            o_out_valid;
  logic            o_busy;
  logic            o_run_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nfu3_ctrl #(.N(N), .NSEG(NSEG), .LAT(LAT), .CNTW(CNTW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cfg_start  (i_cfg_start),
    .i_coef_valid (i_coef_valid),
    .i_coef_data  (i_coef_data),
    .o_coef_ready (o_coef_ready),
    .o_load_coef  (o_load_coef),
    .o_coef_addr  (o_coef_addr),
    .o_coef       (o_coef),
    .o_cfg_done   (o_cfg_done),
    .i_run_start  (i_run_start),
    .i_num_vec    (i_num_vec),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .o_out_valid  (o_out_valid),
    .o_busy       (o_busy),
    .o_run_done   (o_run_done)
  );

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    i_cfg_start = 1'b0; i_coef_valid = 1'b0; i_run_start = 1'b0;
    i_in_valid = 1'b0; i_num_vec = '0;
  endtask

  // All outputs must read zero right now.
  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    step(); #1;
    total++; if (o_coef_ready !== 1'b0) begin bad++; $display("FAIL rst_coef_ready got=%b want=0", o_coef_ready); end
    total++; if (o_load_coef !== 1'b0) begin bad++; $display("FAIL rst_load_coef got=%b want=0", o_load_coef); end
    total++; if (o_coef_addr !== 4'd0) begin bad++; $display("FAIL rst_coef_addr got=%0d want=0", o_coef_addr); end
    total++; if (o_coef !== 32'd0) begin bad++; $display("FAIL rst_coef got=%h want=0", o_coef); end
    total++; if (o_cfg_done !== 1'b0) begin bad++; $display("FAIL rst_cfg_done got=%b want=0", o_cfg_done); end
    total++; if (o_in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", o_in_ready); end
    total++; if (o_out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", o_out_valid); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", o_busy); end
    total++; if (o_run_done !== 1'b0) begin bad++; $display("FAIL rst_run_done got=%b want=0", o_run_done); end
    step(); rst_n = 1'b1;
    step(); #1;
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_release_busy got=%b want=0", o_busy); end
  endtask

  // A run start that must be ignored: nothing moves for several cycles.
  task automatic test_run_rejected(input int nvec, input string tag);
    step(); i_run_start = 1'b1; i_num_vec = CNTW'(nvec); i_in_valid = 1'b1;
    step(); i_run_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL %s_busy cyc=%0d got=%b want=0", tag, k, o_busy); end
      total++; if (o_in_ready !== 1'b0) begin bad++; $display("FAIL %s_in_ready cyc=%0d got=%b want=0", tag, k, o_in_ready); end
      total++; if (o_out_valid !== 1'b0) begin bad++; $display("FAIL %s_out_valid cyc=%0d got=%b want=0", tag, k, o_out_valid); end
      step();
    end
    clear_inputs();
  endtask

  // Coefficient load with random valid gaps (gap = percent idle cycles).
  task automatic test_load(input int gap);
    int nacc, nwr, ndone, guard, pidx;
    bit pv, v;
    logic [31:0] pdata;
    step(); i_cfg_start = 1'b1; i_coef_valid = 1'b0; #1;
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL load_idle_busy got=%b want=0", o_busy); end
    step(); i_cfg_start = 1'b0;
    nacc = 0; nwr = 0; ndone = 0; guard = 0; pv = 0; pidx = 0; pdata = '0;
    while ((nacc < NSEG || pv) && guard < 400) begin
      v = ($urandom_range(99) >= gap);
      i_coef_valid = v;
      i_coef_data  = v ? (32'h0001_0000 + 32'(nacc)) : $urandom;
      #1;
      total++; if (o_coef_ready !== (nacc < NSEG)) begin bad++; $display("FAIL load_ready acc=%0d got=%b want=%b", nacc, o_coef_ready, nacc < NSEG); end
      total++; if (o_busy !== (nacc < NSEG)) begin bad++; $display("FAIL load_busy acc=%0d got=%b want=%b", nacc, o_busy, nacc < NSEG); end
      total++; if (o_load_coef !== pv) begin bad++; $display("FAIL load_we acc=%0d got=%b want=%b", nacc, o_load_coef, pv); end
      total++; if (o_cfg_done !== (pv && pidx == NSEG - 1)) begin bad++; $display("FAIL load_cfg_done acc=%0d got=%b want=%b", nacc, o_cfg_done, pv && pidx == NSEG - 1); end
      if (pv) begin
        total++; if (o_coef_addr !== 4'(pidx)) begin bad++; $display("FAIL load_addr got=%0d want=%0d", o_coef_addr, pidx); end
        total++; if (o_coef !== pdata) begin bad++; $display("FAIL load_data got=%h want=%h", o_coef, pdata); end
        nwr++;
      end
      if (o_cfg_done === 1'b1) ndone++;
      if (v && nacc < NSEG) begin pv = 1; pidx = nacc; pdata = 32'h0001_0000 + 32'(nacc); nacc++; end
      else pv = 0;
      step(); guard++;
    end
    i_coef_valid = 1'b0; #1;
    total++; if (o_coef_ready !== 1'b0) begin bad++; $display("FAIL load_after_ready got=%b want=0", o_coef_ready); end
    total++; if (o_load_coef !== 1'b0) begin bad++; $display("FAIL load_after_we got=%b want=0", o_load_coef); end
    total++; if (nwr !== NSEG) begin bad++; $display("FAIL load_writes got=%0d want=%0d", nwr, NSEG); end
    total++; if (ndone !== 1) begin bad++; $display("FAIL load_done_count got=%0d want=1", ndone); end
    total++; if (guard >= 400) begin bad++; $display("FAIL load_timeout got=%0d want<400", guard); end
  endtask

  // Run of nvec vectors. mode 0: valid held high, 1: random, 2: mask[r].
  // Model: every accepted input at relative cycle r yields a result at r+LAT;
  // the run completes on the nvec-th result.
  task automatic run_seq(input int nvec, input int mode, input logic [31:0] mask,
                         input bit noise, output int done_rel, output int nrdy);
    int q[$];
    int in_left, out_seen, r;
    bit fin, v, ev, ed;
    step(); i_run_start = 1'b1; i_num_vec = CNTW'(nvec); i_in_valid = 1'b0; #1;
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL run_start_busy got=%b want=0", o_busy); end
    step(); i_run_start = 1'b0;
    in_left = nvec; out_seen = 0; r = 0; fin = 0; done_rel = -1; nrdy = 0;
    while (!fin && r < nvec + 40) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = 1'($urandom_range(1));
        default: v = (r < 32) ? mask[r] : 1'b1;
      endcase
      i_in_valid = v;
      if (noise) begin
        i_cfg_start = 1'($urandom_range(1));
        i_run_start = 1'($urandom_range(1));
        i_num_vec   = CNTW'($urandom);
        i_coef_valid = 1'($urandom_range(1));
      end
      #1;
      ev = (q.size() > 0 && q[0] == r);
      if (ev) begin void'(q.pop_front()); out_seen++; end
      ed = ev && (out_seen == nvec);
      total++; if (o_in_ready !== (in_left > 0)) begin bad++; $display("FAIL run_in_ready r=%0d got=%b want=%b", r, o_in_ready, in_left > 0); end
      total++; if (o_out_valid !== ev) begin bad++; $display("FAIL run_out_valid r=%0d got=%b want=%b", r, o_out_valid, ev); end
      total++; if (o_run_done !== ed) begin bad++; $display("FAIL run_done r=%0d got=%b want=%b", r, o_run_done, ed); end
      total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL run_busy r=%0d got=%b want=1", r, o_busy); end
      total++; if (o_load_coef !== 1'b0) begin bad++; $display("FAIL run_load_coef r=%0d got=%b want=0", r, o_load_coef); end
      if (o_in_ready === 1'b1) nrdy++;
      if (v && in_left > 0) begin in_left--; q.push_back(r + LAT); end
      if (ed) begin fin = 1; done_rel = r; end
      step(); r++;
    end
    clear_inputs(); #1;
    total++; if (!fin) begin bad++; $display("FAIL run_timeout got=%0d results want=%0d", out_seen, nvec); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL run_end_busy got=%b want=0", o_busy); end
    total++; if (o_out_valid !== 1'b0) begin bad++; $display("FAIL run_end_out_valid got=%b want=0", o_out_valid); end
    total++; if (o_load_coef !== 1'b0) begin bad++; $display("FAIL run_end_load_coef got=%b want=0", o_load_coef); end
  endtask

  task automatic test_streaming();
    int d, n;
    run_seq(5, 0, 32'h0, 1'b0, d, n);
    total++; if (n !== 5) begin bad++; $display("FAIL stream_ready_cycles got=%0d want=5", n); end
    total++; if (d !== 6) begin bad++; $display("FAIL stream_done_cycle got=%0d want=6", d); end
  endtask

  task automatic test_bubbles();
    int d, n;
    run_seq(3, 2, 32'b11001, 1'b0, d, n);
    total++; if (d !== 6) begin bad++; $display("FAIL bubble_done_cycle got=%0d want=6", d); end
  endtask

  task automatic test_ignored_cmds();
    int d, n;
    run_seq(6, 1, 32'h0, 1'b1, d, n);
    total++; if (n < 6) begin bad++; $display("FAIL ignored_ready_cycles got=%0d want>=6", n); end
  endtask

  task automatic test_back_to_back();
    int d, n, nv;
    for (int k = 0; k < 4; k++) begin
      nv = $urandom_range(12, 1);
      run_seq(nv, k % 2, 32'h0, 1'b0, d, n);
      if (k % 2 == 0) begin
        total++; if (d !== nv - 1 + LAT) begin bad++; $display("FAIL b2b_done_cycle got=%0d want=%0d", d, nv - 1 + LAT); end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    step(); i_run_start = 1'b1; i_num_vec = CNTW'(4);
    step(); i_run_start = 1'b0; i_in_valid = 1'b1;
    step(); step(); #1;
    total++; if (o_out_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre_valid got=%b want=1", o_out_valid); end
    #1 rst_n = 1'b0; #1;
    total++; if (o_out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", o_out_valid); end
    total++; if (o_in_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_ready got=%b want=0", o_in_ready); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", o_busy); end
    total++; if (o_run_done !== 1'b0) begin bad++; $display("FAIL midrst_run_done got=%b want=0", o_run_done); end
    total++; if (o_coef !== 32'd0) begin bad++; $display("FAIL midrst_coef got=%h want=0", o_coef); end
    total++; if (o_coef_addr !== 4'd0) begin bad++; $display("FAIL midrst_coef_addr got=%0d want=0", o_coef_addr); end
    clear_inputs();
    step(); step(); rst_n = 1'b1;
    step(); #1;
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL midrst_release_busy got=%b want=0", o_busy); end
    test_run_rejected(3, "midrst_reject");
  endtask

  task automatic test_max_count();
    int d, n;
    run_seq(65535, 0, 32'h0, 1'b0, d, n);
    total++; if (n !== 65535) begin bad++; $display("FAIL max_ready_cycles got=%0d want=65535", n); end
    total++; if (d !== 65535 - 1 + LAT) begin bad++; $display("FAIL max_done_cycle got=%0d want=%0d", d, 65535 - 1 + LAT); end
  endtask

  initial begin
    test_reset();
    test_run_rejected(5, "noload_reject");
    test_load(30);
    test_run_rejected(0, "zero_vec_reject");
    test_streaming();
    test_bubbles();
    test_ignored_cmds();
    test_back_to_back();
    test_reset_mid_run();
    test_load(60);
    test_back_to_back();
    test_max_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nfu3_ctrl.md
Name: nfu3_ctrl

Overview:
Sequencer for the NFU-3 sigmoid stage. It streams 16 piecewise-linear segment coefficient words (Ai, Bi) into the shared coefficient RAMs of all Tn sigmoid lanes, then admits NFU-2 output vectors and tracks them through the fixed-latency NFU-3 pipeline. It raises output-valid and a completion pulse once the programmed number of vectors has emerged.

Parameters:
N, 16, datapath word width; a coefficient word is 2*N bits, {Ai, Bi}.
NSEG, 16, number of segments and coefficient words per load; address width is clog2(NSEG) = 4.
LAT, 2, NFU-3 latency in cycles, from input sampled to o_Y valid.
CNTW, 16, width of the vector-count field.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
i_cfg_start  in  1  pulse: begin coefficient load; honoured only in IDLE
i_coef_valid  in  1  coefficient word present on i_coef_data
i_coef_data  in  2*N  {Ai, Bi} for the current segment
o_coef_ready  out  1  controller accepts a coefficient word this cycle
o_load_coef  out  1  write enable to the NFU-3 coefficient RAMs
o_coef_addr  out  4  RAM write address (segment index)
o_coef  out  2*N  RAM write data, registered
o_cfg_done  out  1  1-cycle pulse when the last coefficient is written
i_run_start  in  1  pulse: begin processing; honoured only in IDLE with coefficients loaded
i_num_vec  in  CNTW  number of vectors to process; sampled on i_run_start
i_in_valid  in  1  NFU-2 vector valid
o_in_ready  out  1  controller accepts a vector this cycle
o_out_valid  out  1  o_nfu3_out carries a valid result this cycle
o_busy  out  1  high in any state other than IDLE
o_run_done  out  1  1-cycle pulse when the last result is valid

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all counters=0; coef_loaded=0; every output 0, including o_coef.
- States: IDLE, LOAD, RUN, DRAIN.
- IDLE:
  - i_cfg_start -> LOAD with wr_idx=0.
  - Otherwise, i_run_start with coef_loaded=1 and i_num_vec!=0 -> RUN; latch in_left=out_left=i_num_vec.
  - i_run_start with coef_loaded=0 or i_num_vec=0 is ignored.
  - If both starts arrive in the same cycle, cfg wins.
- LOAD:
  - o_coef_ready=1.
  - On handshake (i_coef_valid & o_coef_ready), next cycle: o_load_coef=1, o_coef_addr=wr_idx, o_coef=i_coef_data; wr_idx increments.
  - The cycle the handshake with wr_idx=NSEG-1 occurs: o_coef_ready drops. Next cycle: the final write, o_cfg_done=1, coef_loaded set, state=IDLE.
  - Gaps in i_coef_valid are tolerated; the write address never skips.
- RUN:
  - o_in_ready = (in_left!=0).
  - On an input handshake, in_left decrements and a 1 enters bit 0 of a LAT-deep valid shift register. Otherwise a 0 enters.
  - o_out_valid = shift register bit LAT-1, so it asserts exactly LAT cycles after the input handshake.
  - Each o_out_valid decrements out_left.
  - When in_left reaches 0 -> DRAIN.
- DRAIN:
  - o_in_ready=0; the shift register keeps advancing.
  - The cycle out_left goes 1->0 with o_out_valid: o_run_done=1. Next state=IDLE.
- Back-to-back inputs give back-to-back outputs. There is no output backpressure, because the datapath has no stall.
- i_cfg_start and i_run_start outside IDLE are ignored. The coefficients are never rewritten while vectors are in flight.
- Reset mid-LOAD clears coef_loaded. Software must then reload before a run.
- Counters are CNTW bits. i_num_vec=2^CNTW-1 must complete without wrap.

Decomposition:
- Shared package nfu3_pkg holds the state encoding localparams (IDLE=0, LOAD=1, RUN=2, DRAIN=3), NSEG, and LAT, so that nfu_3 and this controller agree on latency.
- One natural sub-module: valid_pipe (parameterised LAT-deep valid shift register with async active-low reset), reusable for other NFU stages.

Test Plan:
- Load: start, then 16 words 0x00010000+k with random valid gaps -> 16 o_load_coef pulses, addresses 0..15 in order, data matching, o_cfg_done on the 16th write, o_coef_ready low afterwards.
- Run before load: i_run_start with coef_loaded=0 -> no state change, o_busy=0, o_in_ready=0.
- Streaming: load, then run with i_num_vec=5 and i_in_valid held high -> o_in_ready high for exactly 5 cycles; o_out_valid high on cycles t+2..t+6; o_run_done coincides with the 5th valid; then IDLE.
- Bubbles: i_num_vec=3, inputs at cycles 0, 3, 4 -> o_out_valid at 2, 5, 6; o_run_done at 6.
- Ignored commands: i_cfg_start and i_run_start during RUN -> no effect on counts or addresses; no o_load_coef.
- Reset mid-RUN after 2 of 4 inputs -> all outputs 0 immediately; IDLE after release; coef_loaded=0; subsequent run rejected.
